amm_port_arbiter: RTL and testbench
===================================

Name: amm_port_arbiter

Overview:
- Shares the single Avalon-MM memory master port between two requesters.
- Port 0 is the mem_checker transmitter path; port 1 is an auxiliary host/debug master used for memory preload and readback.
- Burst-aware: a write burst holds the grant until its last beat is accepted.
- Read bursts are tagged in a tracking FIFO so returning readdata is steered to the requester that issued it.
- Sits between the requesters and the memory controller, in the clk_mem_i domain.

Parameters:
- ADDR_W, AMM_ADDR_W, memory address width.
- DATA_W, AMM_DATA_W, memory data width.
- BURST_W, AMM_BURST_W, burstcount width.
- BE_W, DATA_B_W, byteenable width.
- RD_FIFO_DEPTH, 8, maximum outstanding read commands. Power of two, at least 2.

Ports:
- clk_i  in  1  memory-domain clock.
- rst_i  in  1  asynchronous reset, active-high.
- m0_address_i / m1_address_i  in  ADDR_W  requester address.
- m0_read_i / m1_read_i  in  1  read request.
- m0_write_i / m1_write_i  in  1  write request.
- m0_writedata_i / m1_writedata_i  in  DATA_W  write data.
- m0_burstcount_i / m1_burstcount_i  in  BURST_W  burst length.
- m0_byteenable_i / m1_byteenable_i  in  BE_W  byte enables.
- m0_waitrequest_o / m1_waitrequest_o  out  1  stall to requester.
- m0_readdatavalid_o / m1_readdatavalid_o  out  1  returned read beat valid.
- m0_readdata_o / m1_readdata_o  out  DATA_W  returned read data.
- mem_address_o, mem_read_o, mem_write_o, mem_writedata_o, mem_burstcount_o, mem_byteenable_o  out  as above  memory command.
- mem_waitrequest_i  in  1  memory stall.
- mem_readdatavalid_i  in  1  memory read beat valid.
- mem_readdata_i  in  DATA_W  memory read data.
- busy_o  out  1  state != IDLE or any read outstanding.
- orphan_err_o  out  1  sticky: readdatavalid arrived with tracking FIFO empty.

Behaviour:
- Reset values:
  - state IDLE, grant 0, rr_ptr 0, FIFO empty, beat counters 0.
  - Outputs: mem_read_o = 0, mem_write_o = 0, both waitrequest_o = 1, both readdatavalid_o = 0, busy_o = 0, orphan_err_o = 0.
  - readdata_o is don't-care.
- State IDLE:
  - No command is forwarded; both waitrequest_o = 1.
  - A requester is requesting if read_i | write_i.
  - If exactly one requests, grant it. If both request, grant the one rr_ptr points to.
  - Register grant; next state GRANT.
  - Latency: a request seen in cycle N appears on mem_* in cycle N+1.
- State GRANT, forwarding:
  - The granted requester's command signals drive mem_* combinationally.
  - mgrant_waitrequest_o = mem_waitrequest_i. The non-granted waitrequest_o = 1.
- GRANT, write:
  - First accepted beat (write & !mem_waitrequest_i) latches burstcount into wr_left. burstcount 0 is treated as 1.
  - Each accepted beat decrements wr_left.
  - The beat that brings wr_left to 0 ends the transaction: next state IDLE, rr_ptr = ~grant.
  - Writes are never blocked by FIFO state.
- GRANT, read:
  - If the tracking FIFO is full, force mem_read_o = 0 and mgrant_waitrequest_o = 1 until an entry pops.
  - Otherwise, on acceptance (read & !mem_waitrequest_i):
    - push {id = grant, len = burstcount, 0 treated as 1};
    - next state IDLE, rr_ptr = ~grant.
- GRANT, requester drops both read and write before acceptance: protocol violation. Return to IDLE next cycle and leave rr_ptr unchanged.
- Read return path:
  - The memory returns beats in command order.
  - Head entry id selects the destination: that requester's readdatavalid_o = mem_readdatavalid_i, and its readdata_o = mem_readdata_i, with zero latency.
  - The other requester's readdatavalid_o = 0.
  - rd_cnt counts beats. When rd_cnt + 1 == head.len on a valid beat: pop, rd_cnt = 0.
- FIFO corner cases:
  - mem_readdatavalid_i with FIFO empty: beat dropped, orphan_err_o set until reset.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A push that coincides with a pop when full-at-start-of-cycle is still blocked, because the full check uses the registered count.
- Arithmetic: wr_left and rd_cnt are BURST_W bits wide. FIFO count is $clog2(RD_FIFO_DEPTH)+1 bits.
- Reset mid-operation: state, FIFO and counters clear immediately. Read beats still in flight after reset set orphan_err_o. Software must reset the memory controller with the arbiter.
- Fairness: after a completed transaction, a continuously requesting requester gets the next grant only if the other is idle in that IDLE cycle.

Decomposition:
- rtl_settings_pkg additions:
  - arb_state_t enum {IDLE, GRANT};
  - rd_track_t packed struct {logic id; logic [AMM_BURST_W-1:0] len};
  - constant RD_TRACK_DEPTH = 8.
- One sub-module: rd_track_fifo. Synchronous show-ahead FIFO of rd_track_t with asynchronous active-high reset. Ports: push, pop, data_i, data_o, empty_o, full_o.

Test Plan:
- m0 write burst of 4 beats at address 0x10 while m1 requests a single write:
  - m1 waitrequest_o stays 1 until m0's 4th beat is accepted;
  - m1 is granted 2 cycles after that beat;
  - mem_write_o sees 4 beats then 1 beat.
- m0 and m1 request reads simultaneously from reset, each with burstcount 2:
  - m0 is granted first (rr_ptr = 0);
  - memory returns 4 beats 0xA,0xB,0xC,0xD;
  - m0 receives 0xA,0xB; m1 receives 0xC,0xD; busy_o falls after 0xD.
- m0 issues 8 single reads while memory withholds readdatavalid:
  - the 9th read holds m0_waitrequest_o = 1 and mem_read_o = 0;
  - one returned beat releases it the next cycle.
- mem_waitrequest_i held 1 for 5 cycles mid write burst: the beat count is unaffected, the burst completes with exactly burstcount beats, and there is no grant switch.
- mem_readdatavalid_i pulses with no outstanding reads: orphan_err_o = 1, both readdatavalid_o stay 0, and orphan_err_o remains 1 until rst_i.
- rst_i asserted in the middle of a 3-beat read return:
  - outputs immediately go to reset values and the FIFO empties;
  - the next beat sets orphan_err_o;
  - a new m1 read is then granted normally.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// Shared memory-interface widths and types for the Avalon-MM port arbiter.
// Also holds the read-tracking entry that steers returning beats to their requester.
package rtl_settings_pkg;

  localparam int AMM_ADDR_W     = 26;
  localparam int AMM_DATA_W     = 32;
  localparam int AMM_BURST_W    = 7;
  localparam int DATA_B_W       = 4;
  localparam int RD_TRACK_DEPTH = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef struct packed {
    logic                   id;
    logic [AMM_BURST_W-1:0] len;
  } rd_track_t;

endpackage

// File: rtl/rd_track_fifo.sv
// Show-ahead FIFO of outstanding read bursts; the head entry is visible on data_o
// without a read latency so returning beats can be routed in the same cycle.
module rd_track_fifo
  import rtl_settings_pkg::*;
#(
  parameter int DEPTH = RD_TRACK_DEPTH
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push,
  input  logic      pop,
  input  rd_track_t data_i,
  output rd_track_t data_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  rd_track_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_push = push & ~full_o;
  assign do_pop  = pop & ~empty_o;
  assign data_o  = mem[rd_ptr_reg];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= data_i;
  end

endmodule

// File: rtl/amm_port_arbiter.sv
// Two-port Avalon-MM arbiter: round-robin grant per transaction, write bursts hold
// the grant to their last beat, read bursts are tracked to route readdata back.
module amm_port_arbiter
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W        = AMM_ADDR_W,
  parameter int DATA_W        = AMM_DATA_W,
  parameter int BURST_W       = AMM_BURST_W,
  parameter int BE_W          = DATA_B_W,
  parameter int RD_FIFO_DEPTH = RD_TRACK_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  m0_address_i,
  input  logic               m0_read_i,
  input  logic               m0_write_i,
  input  logic [DATA_W-1:0]  m0_writedata_i,
  input  logic [BURST_W-1:0] m0_burstcount_i,
  input  logic [BE_W-1:0]    m0_byteenable_i,
  output logic               m0_waitrequest_o,
  output logic               m0_readdatavalid_o,
  output logic [DATA_W-1:0]  m0_readdata_o,
  input  logic [ADDR_W-1:0]  m1_address_i,
  input  logic               m1_read_i,
  input  logic               m1_write_i,
  input  logic [DATA_W-1:0]  m1_writedata_i,
  input  logic [BURST_W-1:0] m1_burstcount_i,
  input  logic [BE_W-1:0]    m1_byteenable_i,
  output logic               m1_waitrequest_o,
  output logic               m1_readdatavalid_o,
  output logic [DATA_W-1:0]  m1_readdata_o,
  output logic [ADDR_W-1:0]  mem_address_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [DATA_W-1:0]  mem_writedata_o,
  output logic [BURST_W-1:0] mem_burstcount_o,
  output logic [BE_W-1:0]    mem_byteenable_o,
  input  logic               mem_waitrequest_i,
  input  logic               mem_readdatavalid_i,
  input  logic [DATA_W-1:0]  mem_readdata_i,
  output logic               busy_o,
  output logic               orphan_err_o
);

  arb_state_t   state_reg, state_next;
  logic         grant_reg, grant_next;
  logic         rr_ptr_reg, rr_ptr_next;
  logic [BURST_W-1:0] wr_left_reg, wr_left_next;
  logic         wr_started_reg, wr_started_next;
  logic [BURST_W-1:0] rd_cnt_reg, rd_cnt_next;
  logic         orphan_reg, orphan_next;

  // Requester views indexed by port number so the grant can select them directly.
  logic [1:0]         p_read, p_write, p_req, p_wait, p_rdv;
  logic [ADDR_W-1:0]  p_addr  [2];
  logic [DATA_W-1:0]  p_wdata [2];
  logic [BURST_W-1:0] p_bc    [2];
  logic [BE_W-1:0]    p_be    [2];

  logic               g_read, g_write, g_wait, fwd, rd_blocked;
  logic [BURST_W-1:0] g_bc, eff_bc, wr_left_cur, wr_left_dec;
  logic               wr_acc, rd_acc;

  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  rd_track_t          fifo_din, fifo_head;
  logic               rd_route, rd_last;
  logic [BURST_W-1:0] head_len;

  assign p_read     = {m1_read_i, m0_read_i};
  assign p_write    = {m1_write_i, m0_write_i};
  assign p_req      = p_read | p_write;
  assign p_addr[0]  = m0_address_i;
  assign p_addr[1]  = m1_address_i;
  assign p_wdata[0] = m0_writedata_i;
  assign p_wdata[1] = m1_writedata_i;
  assign p_bc[0]    = m0_burstcount_i;
  assign p_bc[1]    = m1_burstcount_i;
  assign p_be[0]    = m0_byteenable_i;
  assign p_be[1]    = m1_byteenable_i;

  assign fwd     = (state_reg == GRANT);
  assign g_read  = p_read[grant_reg];
  assign g_write = p_write[grant_reg];
  assign g_bc    = p_bc[grant_reg];
  assign eff_bc  = (g_bc == '0) ? BURST_W'(1) : g_bc;

  // A write takes precedence if a requester illegally asserts both strobes.
  assign rd_blocked = g_read & ~g_write & fifo_full;
  assign g_wait     = mem_waitrequest_i | rd_blocked;

  assign mem_address_o    = p_addr[grant_reg];
  assign mem_writedata_o  = p_wdata[grant_reg];
  assign mem_burstcount_o = g_bc;
  assign mem_byteenable_o = p_be[grant_reg];
  assign mem_write_o      = fwd & g_write;
  assign mem_read_o       = fwd & g_read & ~g_write & ~fifo_full;

  assign wr_acc      = mem_write_o & ~mem_waitrequest_i;
  assign rd_acc      = mem_read_o & ~mem_waitrequest_i;
  assign wr_left_cur = wr_started_reg ? wr_left_reg : eff_bc;
  assign wr_left_dec = wr_left_cur - 1'b1;

  assign fifo_din.id  = grant_reg;
  assign fifo_din.len = AMM_BURST_W'(eff_bc);

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    rr_ptr_next     = rr_ptr_reg;
    wr_left_next    = wr_left_reg;
    wr_started_next = wr_started_reg;
    fifo_push       = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_started_next = 1'b0;
        if (|p_req) begin
          state_next = GRANT;
          grant_next = (&p_req) ? rr_ptr_reg : p_req[1];
        end
      end
      GRANT: begin
        if (wr_acc) begin
          if (wr_left_dec == '0) begin
            state_next      = IDLE;
            rr_ptr_next     = ~grant_reg;
            wr_started_next = 1'b0;
          end else begin
            wr_started_next = 1'b1;
          end
          wr_left_next = wr_left_dec;
        end else if (rd_acc) begin
          fifo_push   = 1'b1;
          state_next  = IDLE;
          rr_ptr_next = ~grant_reg;
        end else if (!g_read && !g_write && !wr_started_reg) begin
          // Requester abandoned an unaccepted command; do not charge it a turn.
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Return path: memory answers in command order, so the FIFO head owns every beat.
  assign head_len = BURST_W'(fifo_head.len);
  assign rd_route = mem_readdatavalid_i & ~fifo_empty;
  assign rd_last  = ((rd_cnt_reg + 1'b1) == head_len);
  assign fifo_pop = rd_route & rd_last;

  always_comb begin
    rd_cnt_next = rd_cnt_reg;
    if (rd_route) rd_cnt_next = rd_last ? '0 : rd_cnt_reg + 1'b1;
    orphan_next = orphan_reg | (mem_readdatavalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      rr_ptr_reg     <= 1'b0;
      wr_left_reg    <= '0;
      wr_started_reg <= 1'b0;
      rd_cnt_reg     <= '0;
      orphan_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      wr_left_reg    <= wr_left_next;
      wr_started_reg <= wr_started_next;
      rd_cnt_reg     <= rd_cnt_next;
      orphan_reg     <= orphan_next;
    end
  end

  rd_track_fifo #(
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_track_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .data_i  (fifo_din),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign p_wait[gi] = ~(fwd && grant_reg == 1'(gi)) | g_wait;
      assign p_rdv[gi]  = rd_route & (fifo_head.id == 1'(gi));
    end
  endgenerate

  assign m0_waitrequest_o   = p_wait[0];
  assign m1_waitrequest_o   = p_wait[1];
  assign m0_readdatavalid_o = p_rdv[0];
  assign m1_readdatavalid_o = p_rdv[1];
  assign m0_readdata_o      = mem_readdata_i;
  assign m1_readdata_o      = mem_readdata_i;

  assign busy_o       = (state_reg != IDLE) | ~fifo_empty;
  assign orphan_err_o = orphan_reg;

endmodule

// File: tb/tb_amm_port_arbiter.sv
// Directed bench for amm_port_arbiter: write-burst hold, read steering, FIFO-full
// stall, orphan detection and reset in the middle of a read return.
module tb_amm_port_arbiter;

  logic        clk_i, rst_i;
  logic [25:0] m0_address_i, m1_address_i, mem_address_o;
  logic        m0_read_i, m0_write_i, m1_read_i, m1_write_i;
  logic [31:0] m0_writedata_i, m1_writedata_i, m0_readdata_o, m1_readdata_o;
  logic [6:0]  m0_burstcount_i, m1_burstcount_i, mem_burstcount_o;
  logic [3:0]  m0_byteenable_i, m1_byteenable_i, mem_byteenable_o;
  logic        m0_waitrequest_o, m1_waitrequest_o;
  logic        m0_readdatavalid_o, m1_readdatavalid_o;
  logic        mem_read_o, mem_write_o;
  logic [31:0] mem_writedata_o, mem_readdata_i;
  logic        mem_waitrequest_i, mem_readdatavalid_i;
  logic        busy_o, orphan_err_o;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  amm_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_address_i(m0_address_i), .m0_read_i(m0_read_i), .m0_write_i(m0_write_i),
    .m0_writedata_i(m0_writedata_i), .m0_burstcount_i(m0_burstcount_i),
    .m0_byteenable_i(m0_byteenable_i), .m0_waitrequest_o(m0_waitrequest_o),
    .m0_readdatavalid_o(m0_readdatavalid_o), .m0_readdata_o(m0_readdata_o),
    .m1_address_i(m1_address_i), .m1_read_i(m1_read_i), .m1_write_i(m1_write_i),
    .m1_writedata_i(m1_writedata_i), .m1_burstcount_i(m1_burstcount_i),
    .m1_byteenable_i(m1_byteenable_i), .m1_waitrequest_o(m1_waitrequest_o),
    .m1_readdatavalid_o(m1_readdatavalid_o), .m1_readdata_o(m1_readdata_o),
    .mem_address_o(mem_address_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_writedata_o(mem_writedata_o), .mem_burstcount_o(mem_burstcount_o),
    .mem_byteenable_o(mem_byteenable_o), .mem_waitrequest_i(mem_waitrequest_i),
    .mem_readdatavalid_i(mem_readdatavalid_i), .mem_readdata_i(mem_readdata_i),
    .busy_o(busy_o), .orphan_err_o(orphan_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    m0_address_i = '0; m0_read_i = 0; m0_write_i = 0; m0_writedata_i = '0;
    m0_burstcount_i = '0; m0_byteenable_i = '0;
    m1_address_i = '0; m1_read_i = 0; m1_write_i = 0; m1_writedata_i = '0;
    m1_burstcount_i = '0; m1_byteenable_i = '0;
    mem_waitrequest_i = 0; mem_readdatavalid_i = 0; mem_readdata_i = '0;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;

    // Reset state
    sample();
    check("rst_mem_read", mem_read_o, 0);
    check("rst_mem_write", mem_write_o, 0);
    check("rst_m0_wait", m0_waitrequest_o, 1);
    check("rst_m1_wait", m1_waitrequest_o, 1);
    check("rst_m0_rdv", m0_readdatavalid_o, 0);
    check("rst_m1_rdv", m1_readdatavalid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_orphan", orphan_err_o, 0);
    step();
    rst_i = 1'b0;
    $display("tb: reset checked");

    // m0 4-beat write at 0x10 with a 5-cycle stall after beat 2; m1 single write waits
    m0_write_i = 1; m0_address_i = 26'h10; m0_burstcount_i = 7'd4;
    m0_writedata_i = 32'hD000_0000; m0_byteenable_i = 4'hF;
    m1_write_i = 1; m1_address_i = 26'h20; m1_burstcount_i = 7'd1;
    m1_writedata_i = 32'h1111_1111; m1_byteenable_i = 4'h3;
    sample();
    check("t1_idle_mem_write", mem_write_o, 0);
    check("t1_idle_m0_wait", m0_waitrequest_o, 1);
    step();
    for (int cyc = 0; cyc < 9; cyc++) begin
      int idx;
      logic stall;
      stall = (cyc >= 2 && cyc < 7);
      idx   = (cyc < 2) ? cyc : ((cyc < 7) ? 2 : cyc - 5);
      mem_waitrequest_i = stall;
      sample();
      check("t1_mem_write", mem_write_o, 1);
      check("t1_mem_addr", mem_address_o, 26'h10);
      check("t1_wdata", mem_writedata_o, 32'hD000_0000 + idx);
      check("t1_m0_wait", m0_waitrequest_o, stall);
      check("t1_m1_wait", m1_waitrequest_o, 1);
      if (mem_write_o && !mem_waitrequest_i) beats++;
      step();
      if (!stall) m0_writedata_i = 32'hD000_0000 + idx + 1;
    end
    m0_write_i = 0; mem_waitrequest_i = 0;
    sample();
    check("t1_gap_mem_write", mem_write_o, 0);
    check("t1_gap_m1_wait", m1_waitrequest_o, 1);
    check("t1_m0_beats", beats, 4);
    step();
    sample();
    check("t1_m1_mem_write", mem_write_o, 1);
    check("t1_m1_addr", mem_address_o, 26'h20);
    check("t1_m1_be", mem_byteenable_o, 4'h3);
    check("t1_m1_wdata", mem_writedata_o, 32'h1111_1111);
    check("t1_m1_wait", m1_waitrequest_o, 0);
    check("t1_m0_wait_after", m0_waitrequest_o, 1);
    if (mem_write_o && !mem_waitrequest_i) beats++;
    step();
    m1_write_i = 0;
    sample();
    check("t1_end_mem_write", mem_write_o, 0);
    check("t1_end_busy", busy_o, 0);
    check("t1_total_beats", beats, 5);
    $display("tb: write burst m0 x4 then m1 x1 done");

    // Simultaneous reads from reset, burstcount 2 each
    rst_i = 1; step(); rst_i = 0;
    m0_read_i = 1; m0_address_i = 26'h100; m0_burstcount_i = 7'd2;
    m1_read_i = 1; m1_address_i = 26'h200; m1_burstcount_i = 7'd2;
    sample();
    check("t2_idle_m0_wait", m0_waitrequest_o, 1);
    check("t2_idle_m1_wait", m1_waitrequest_o, 1);
    step();
    sample();
    check("t2_g0_read", mem_read_o, 1);
    check("t2_g0_addr", mem_address_o, 26'h100);
    check("t2_g0_bc", mem_burstcount_o, 7'd2);
    check("t2_g0_m0_wait", m0_waitrequest_o, 0);
    check("t2_g0_m1_wait", m1_waitrequest_o, 1);
    step();
    m0_read_i = 0;
    sample();
    check("t2_idle2_read", mem_read_o, 0);
    check("t2_idle2_busy", busy_o, 1);
    step();
    sample();
    check("t2_g1_read", mem_read_o, 1);
    check("t2_g1_addr", mem_address_o, 26'h200);
    check("t2_g1_m1_wait", m1_waitrequest_o, 0);
    step();
    m1_read_i = 0;
    for (int i = 0; i < 4; i++) begin
      logic to_m0;
      to_m0 = (i < 2);
      mem_readdatavalid_i = 1; mem_readdata_i = 32'hA + i;
      sample();
      check("t2_m0_rdv", m0_readdatavalid_o, to_m0);
      check("t2_m1_rdv", m1_readdatavalid_o, !to_m0);
      if (to_m0) check("t2_m0_data", m0_readdata_o, 32'hA + i);
      else       check("t2_m1_data", m1_readdata_o, 32'hA + i);
      check("t2_busy_during", busy_o, 1);
      step();
    end
    mem_readdatavalid_i = 0;
    sample();
    check("t2_busy_after", busy_o, 0);
    $display("tb: dual read bursts returned");

    // Eight single reads fill the tracking FIFO; the ninth stalls until one pops
    m0_read_i = 1; m0_address_i = 26'h300; m0_burstcount_i = 7'd1;
    for (int k = 0; k < 8; k++) begin
      step();
      sample();
      check("t3_fill_read", mem_read_o, 1);
      check("t3_fill_m0_wait", m0_waitrequest_o, 0);
      step();
      sample();
      check("t3_fill_idle", mem_read_o, 0);
    end
    step();
    for (int s = 0; s < 2; s++) begin
      sample();
      check("t3_full_read", mem_read_o, 0);
      check("t3_full_m0_wait", m0_waitrequest_o, 1);
      check("t3_full_busy", busy_o, 1);
      step();
    end
    mem_readdatavalid_i = 1; mem_readdata_i = 32'h55;
    sample();
    check("t3_pop_rdv", m0_readdatavalid_o, 1);
    check("t3_pop_data", m0_readdata_o, 32'h55);
    check("t3_pop_still_blocked", mem_read_o, 0);
    step();
    mem_readdatavalid_i = 0;
    sample();
    check("t3_release_read", mem_read_o, 1);
    check("t3_release_m0_wait", m0_waitrequest_o, 0);
    step();
    m0_read_i = 0;
    mem_readdatavalid_i = 1;
    for (int j = 0; j < 8; j++) begin
      sample();
      check("t3_drain_rdv", m0_readdatavalid_o, 1);
      step();
    end
    mem_readdatavalid_i = 0;
    sample();
    check("t3_drain_busy", busy_o, 0);
    check("t3_no_orphan", orphan_err_o, 0);
    $display("tb: fifo full stall and drain done");

    // Orphan beat
    mem_readdatavalid_i = 1;
    sample();
    check("t4_m0_rdv", m0_readdatavalid_o, 0);
    check("t4_m1_rdv", m1_readdatavalid_o, 0);
    step();
    mem_readdatavalid_i = 0;
    sample();
    check("t4_orphan_set", orphan_err_o, 1);
    step(); step();
    sample();
    check("t4_orphan_sticky", orphan_err_o, 1);
    $display("tb: orphan beat flagged");

    // Reset in the middle of a 3-beat read return
    rst_i = 1; step(); rst_i = 0;
    sample();
    check("t5_orphan_cleared", orphan_err_o, 0);
    m1_read_i = 1; m1_address_i = 26'h400; m1_burstcount_i = 7'd3;
    step();
    sample();
    check("t5_read", mem_read_o, 1);
    check("t5_bc", mem_burstcount_o, 7'd3);
    check("t5_m1_wait", m1_waitrequest_o, 0);
    step();
    m1_read_i = 0;
    mem_readdatavalid_i = 1; mem_readdata_i = 32'h77;
    sample();
    check("t5_beat0_rdv", m1_readdatavalid_o, 1);
    check("t5_beat0_data", m1_readdata_o, 32'h77);
    check("t5_beat0_busy", busy_o, 1);
    step();
    mem_readdatavalid_i = 0;
    rst_i = 1;
    #1;
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_m0_wait", m0_waitrequest_o, 1);
    check("t5_rst_m1_wait", m1_waitrequest_o, 1);
    check("t5_rst_read", mem_read_o, 0);
    step();
    rst_i = 0;
    mem_readdatavalid_i = 1; mem_readdata_i = 32'h78;
    sample();
    check("t5_late_m1_rdv", m1_readdatavalid_o, 0);
    check("t5_late_m0_rdv", m0_readdatavalid_o, 0);
    step();
    mem_readdatavalid_i = 0;
    sample();
    check("t5_late_orphan", orphan_err_o, 1);
    m1_read_i = 1; m1_address_i = 26'h404; m1_burstcount_i = 7'd1;
    step();
    sample();
    check("t5_new_read", mem_read_o, 1);
    check("t5_new_addr", mem_address_o, 26'h404);
    check("t5_new_m1_wait", m1_waitrequest_o, 0);
    step();
    m1_read_i = 0;
    mem_readdatavalid_i = 1; mem_readdata_i = 32'h99;
    sample();
    check("t5_new_rdv", m1_readdatavalid_o, 1);
    check("t5_new_data", m1_readdata_o, 32'h99);
    step();
    mem_readdatavalid_i = 0;
    sample();
    check("t5_final_busy", busy_o, 0);
    $display("tb: reset mid-return and recovery done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
